// File: rtl/calc_input_sequencer.sv
// calc_input_sequencer: debounced key-driven entry of operand A, operator, operand B
// for the 3-bit calculator. Define SEQ_TIMEOUT_EN to enable the idle auto-clear.
`timescale 1ns/1ps

module calc_input_sequencer #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int TIMEOUT_CYCLES  = 500000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] sw_num,
   input  logic [3:0] sw_op,
   input  logic       key_enter_n,
   input  logic       key_clear_n,
   output logic [2:0] num1,
   output logic [2:0] num2,
   output logic       add,
   output logic       sub,
   output logic       multi,
   output logic       div,
   output logic [3:0] state_led,
   output logic       op_err
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   // State encoding doubles as the one-hot LED pattern.
   typedef enum logic [3:0] {
      GET_A  = 4'b0001,
      GET_OP = 4'b0010,
      GET_B  = 4'b0100,
      SHOW   = 4'b1000
   } state_t;

   state_t          state, state_n;
   logic [2:0]      num_meta, num_sync;
   logic [3:0]      op_meta, op_sync;
   logic [1:0]      key_meta, key_sync;
   logic [1:0]      key_level;
   logic [1:0]      press_evt;
   logic [DB_W-1:0] db_cnt [2];
   logic            enter_evt, clear_evt, timeout_hit, op_onehot;
   logic [2:0]      num1_n, num2_n;
   logic [3:0]      op_sel, op_sel_n, op_out, op_out_n;
   logic            op_err_n;

   // Keys idle high, so their synchronizers come out of reset as "released".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num_meta <= '0;
         num_sync <= '0;
         op_meta  <= '0;
         op_sync  <= '0;
         key_meta <= 2'b11;
         key_sync <= 2'b11;
      end else begin
         num_meta <= sw_num;
         num_sync <= num_meta;
         op_meta  <= sw_op;
         op_sync  <= op_meta;
         key_meta <= {key_clear_n, key_enter_n};
         key_sync <= key_meta;
      end
   end

   // Index 0 is enter, index 1 is clear; only the debounced falling edge is an event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_level <= 2'b11;
         press_evt <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            press_evt[i] <= 1'b0;
            if (key_sync[i] == key_level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db_cnt[i]    <= '0;
               key_level[i] <= key_sync[i];
               press_evt[i] <= ~key_sync[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   assign enter_evt = press_evt[0];
   assign clear_evt = press_evt[1];
   assign op_onehot = (op_sync != 4'd0) && ((op_sync & (op_sync - 4'd1)) == 4'd0);

`ifdef SEQ_TIMEOUT_EN
   localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT_CYCLES - 1);

   logic [31:0] idle_cnt;

   // Any key activity restarts the idle window; GET_A never times out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt <= '0;
      end else if (state == GET_A || enter_evt || clear_evt || timeout_hit) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + 32'd1;
      end
   end

   assign timeout_hit = (state != GET_A) && (idle_cnt == IDLE_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   // Clear (or timeout) outranks enter when both arrive on the same cycle.
   always_comb begin
      state_n  = state;
      num1_n   = num1;
      num2_n   = num2;
      op_sel_n = op_sel;
      op_out_n = op_out;
      op_err_n = 1'b0;
      if (clear_evt || timeout_hit) begin
         state_n  = GET_A;
         num1_n   = '0;
         num2_n   = '0;
         op_sel_n = '0;
         op_out_n = '0;
      end else if (enter_evt) begin
         case (state)
            GET_A: begin
               num1_n  = num_sync;
               state_n = GET_OP;
            end
            GET_OP: begin
               if (op_onehot) begin
                  op_sel_n = op_sync;
                  state_n  = GET_B;
               end else begin
                  op_err_n = 1'b1;
               end
            end
            GET_B: begin
               num2_n   = num_sync;
               op_out_n = op_sel;
               state_n  = SHOW;
            end
            SHOW: begin
               num1_n   = '0;
               num2_n   = '0;
               op_sel_n = '0;
               op_out_n = '0;
               state_n  = GET_A;
            end
            default: begin
               state_n = GET_A;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= GET_A;
         num1   <= '0;
         num2   <= '0;
         op_sel <= '0;
         op_out <= '0;
         op_err <= 1'b0;
      end else begin
         state  <= state_n;
         num1   <= num1_n;
         num2   <= num2_n;
         op_sel <= op_sel_n;
         op_out <= op_out_n;
         op_err <= op_err_n;
      end
   end

   assign {add, sub, multi, div} = op_out;
   assign state_led              = state;

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Self-checking bench for calc_input_sequencer: directed entry scenarios plus random
// key/switch activity, compared every cycle against a sliding-window reference model.
`timescale 1ns/1ps

module tb_calc_input_sequencer;

   localparam int DEB = 4;
   localparam int TMO = 50;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [2:0] sw_num;
   logic [3:0] sw_op;
   logic       key_enter_n, key_clear_n;
   logic [2:0] num1, num2;
   logic       add, sub, multi, div;
   logic [3:0] state_led;
   logic       op_err;

   int n_compared   = 0;
   int n_mismatched = 0;
   int err_seen     = 0;
   bit check_en     = 0;

   always #5 clk = ~clk;

   calc_input_sequencer #(
      .DEBOUNCE_CYCLES(DEB),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw_num     (sw_num),
      .sw_op      (sw_op),
      .key_enter_n(key_enter_n),
      .key_clear_n(key_clear_n),
      .num1       (num1),
      .num2       (num2),
      .add        (add),
      .sub        (sub),
      .multi      (multi),
      .div        (div),
      .state_led  (state_led),
      .op_err     (op_err)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Reference model: a key level is accepted once the last DEB synchronized samples
   // all disagree with the current accepted level; the FSM consumes events a cycle later.
   int          cyc = 0;
   int          m_anchor;
   int          m_state;
   logic [1:0]  key_hist [DEB+1];
   logic [2:0]  num_hist [2];
   logic [3:0]  op_hist  [2];
   logic [1:0]  m_level, m_evt, new_evt;
   logic [2:0]  m_num1, m_num2, s_num;
   logic [3:0]  m_op_sel, m_op_out, s_op;
   logic        m_err;
   bit          timeout, all_diff;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j <= DEB; j++) key_hist[j] = 2'b11;
         num_hist[0] = '0; num_hist[1] = '0;
         op_hist[0]  = '0; op_hist[1]  = '0;
         m_level  = 2'b11;
         m_evt    = 2'b00;
         m_state  = 0;
         m_num1   = '0;
         m_num2   = '0;
         m_op_sel = '0;
         m_op_out = '0;
         m_err    = 1'b0;
         m_anchor = cyc;
      end else begin
         cyc++;
         s_num   = num_hist[1];
         s_op    = op_hist[1];
         timeout = 0;
`ifdef SEQ_TIMEOUT_EN
         timeout = (m_state != 0) && (cyc - m_anchor == TMO);
`endif
         m_err = 1'b0;
         if (m_evt != 2'b00) m_anchor = cyc;
         if (timeout || m_evt[1] || (m_evt[0] && m_state == 3)) begin
            m_state = 0; m_num1 = '0; m_num2 = '0; m_op_sel = '0; m_op_out = '0;
         end else if (m_evt[0]) begin
            case (m_state)
               0: begin m_num1 = s_num; m_state = 1; end
               1: begin
                  if ($countones(s_op) == 1) begin m_op_sel = s_op; m_state = 2; end
                  else m_err = 1'b1;
               end
               default: begin m_num2 = s_num; m_op_out = m_op_sel; m_state = 3; end
            endcase
         end
         for (int k = 0; k < 2; k++) begin
            all_diff = 1;
            for (int j = 1; j <= DEB; j++) if (key_hist[j][k] == m_level[k]) all_diff = 0;
            new_evt[k] = 1'b0;
            if (all_diff) begin
               m_level[k] = ~m_level[k];
               new_evt[k] = ~m_level[k];
            end
         end
         m_evt = new_evt;
         for (int j = DEB; j >= 1; j--) key_hist[j] = key_hist[j-1];
         key_hist[0] = {key_clear_n, key_enter_n};
         num_hist[1] = num_hist[0]; num_hist[0] = sw_num;
         op_hist[1]  = op_hist[0];  op_hist[0]  = sw_op;
      end
   end

   always @(negedge clk) begin
      if (check_en && rst_n === 1'b1) begin
         checkOutput("num1", num1, m_num1);
         checkOutput("num2", num2, m_num2);
         checkOutput("op_lines", {add, sub, multi, div}, m_op_out);
         checkOutput("state_led", state_led, 4'b0001 << m_state);
         checkOutput("op_err", op_err, m_err);
         if (op_err === 1'b1) err_seen++;
      end
   end

   task automatic applyStimulus(input logic [2:0] num, input logic [3:0] op,
                                input logic ent_n, input logic clr_n, input int cycles);
      sw_num      = num;
      sw_op       = op;
      key_enter_n = ent_n;
      key_clear_n = clr_n;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic pressKeys(input logic [2:0] num, input logic [3:0] op, input logic ent, input logic clr);
      applyStimulus(num, op, ~ent, ~clr, DEB + 6);
      applyStimulus(num, op, 1'b1, 1'b1, DEB + 6);
   endtask

   initial begin
      #1ms;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      sw_num = '0; sw_op = '0; key_enter_n = 1'b1; key_clear_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_led", state_led, 4'b0001);
      checkOutput("rst_num", {num1, num2}, 6'd0);
      checkOutput("rst_op", {add, sub, multi, div, op_err}, 5'd0);
      rst_n    = 1'b1;
      check_en = 1;
      applyStimulus(3'd0, 4'd0, 1'b1, 1'b1, 4);

      $display("[TB] full sequence");
      pressKeys(3'b101, 4'b0000, 1'b1, 1'b0);
      checkOutput("seq_a_led", state_led, 4'b0010);
      checkOutput("seq_a_num1", num1, 3'd5);
      pressKeys(3'b101, 4'b0010, 1'b1, 1'b0);
      checkOutput("seq_op_led", state_led, 4'b0100);
      checkOutput("seq_op_lines", {add, sub, multi, div}, 4'b0000);
      pressKeys(3'b011, 4'b0010, 1'b1, 1'b0);
      checkOutput("seq_b_led", state_led, 4'b1000);
      checkOutput("seq_b_nums", {num1, num2}, {3'd5, 3'd3});
      checkOutput("seq_b_multi", {add, sub, multi, div}, 4'b0010);
      applyStimulus(3'b111, 4'b1111, 1'b1, 1'b1, 10);
      checkOutput("show_hold", {num1, num2, add, sub, multi, div}, {3'd5, 3'd3, 4'b0010});
      pressKeys(3'b111, 4'b1111, 1'b1, 1'b0);
      checkOutput("show_exit", {state_led, num1, num2, add, sub, multi, div}, {4'b0001, 10'd0});

      $display("[TB] bounce");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(3'd6, 4'd0, 1'b0, 1'b1, 2);
         applyStimulus(3'd6, 4'd0, 1'b1, 1'b1, 2);
      end
      checkOutput("bounce_idle", state_led, 4'b0001);
      applyStimulus(3'd6, 4'd0, 1'b0, 1'b1, 10);
      applyStimulus(3'd2, 4'd0, 1'b0, 1'b1, 10);
      applyStimulus(3'd2, 4'd0, 1'b1, 1'b1, 10);
      checkOutput("bounce_led", state_led, 4'b0010);
      checkOutput("bounce_num1", num1, 3'd6);

      $display("[TB] bad operator");
      err_seen = 0;
      pressKeys(3'd0, 4'b1100, 1'b1, 1'b0);
      checkOutput("bad_op_pulses", err_seen, 1);
      checkOutput("bad_op_led", state_led, 4'b0010);
      pressKeys(3'd0, 4'b1000, 1'b1, 1'b0);
      checkOutput("good_op_led", state_led, 4'b0100);
      pressKeys(3'd2, 4'b0001, 1'b1, 1'b0);
      checkOutput("add_show", {add, sub, multi, div, num2}, {4'b1000, 3'd2});
      pressKeys(3'd0, 4'd0, 1'b1, 1'b0);

      $display("[TB] clear priority");
      pressKeys(3'd7, 4'd0, 1'b1, 1'b0);
      pressKeys(3'd7, 4'b0100, 1'b1, 1'b0);
      checkOutput("pre_clear_led", state_led, 4'b0100);
      pressKeys(3'd4, 4'b0100, 1'b1, 1'b1);
      checkOutput("clear_led", state_led, 4'b0001);
      checkOutput("clear_nums", {num1, num2}, 6'd0);

      $display("[TB] async reset");
      pressKeys(3'd1, 4'd0, 1'b1, 1'b0);
      pressKeys(3'd1, 4'b0001, 1'b1, 1'b0);
      pressKeys(3'd2, 4'b0001, 1'b1, 1'b0);
      checkOutput("pre_rst_led", state_led, 4'b1000);
      applyStimulus(3'd2, 4'b0001, 1'b0, 1'b1, 3);
      #2 rst_n = 1'b0;
      #0.5;
      checkOutput("arst_led", state_led, 4'b0001);
      checkOutput("arst_outs", {num1, num2, add, sub, multi, div, op_err}, 11'd0);
      #0.5 rst_n = 1'b1;
      key_enter_n = 1'b1;
      @(negedge clk);
      applyStimulus(3'd2, 4'b0001, 1'b1, 1'b1, 20);
      checkOutput("arst_discard", state_led, 4'b0001);

      $display("[TB] idle timeout");
      pressKeys(3'd4, 4'd0, 1'b1, 1'b0);
      checkOutput("idle_start", state_led, 4'b0010);
`ifdef SEQ_TIMEOUT_EN
      applyStimulus(3'd4, 4'd0, 1'b1, 1'b1, 40);
      checkOutput("timeout_led", state_led, 4'b0001);
      checkOutput("timeout_num1", num1, 3'd0);
`else
      applyStimulus(3'd4, 4'd0, 1'b1, 1'b1, 1000);
      checkOutput("no_timeout_led", state_led, 4'b0010);
      checkOutput("no_timeout_num1", num1, 3'd4);
`endif
      pressKeys(3'd0, 4'd0, 1'b0, 1'b1);

      $display("[TB] random activity");
      for (int i = 0; i < 400; i++) begin
         logic [3:0] rop;
         rop = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
         applyStimulus(3'($urandom), rop, 1'($urandom), ($urandom_range(0, 9) != 0),
                       $urandom_range(1, 12));
      end
      applyStimulus(3'd0, 4'd0, 1'b1, 1'b1, 20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/calc_input_sequencer.md
Name: calc_input_sequencer

Overview:
- Upstream stage of the 3-bit calculator datapath.
- Replaces direct switch wiring with a key-driven entry sequence: operand A, then operator, then operand B.
- Debounces the board push-buttons and latches operands and operator in registers.
- Drives registered num1/num2 and one-hot add/sub/multi/div into the compute/display stage; operator lines are asserted only once entry is complete.

Parameters:
- DEBOUNCE_CYCLES, 250000, clock cycles a synchronized key level must stay stable before it is accepted (5 ms at 50 MHz).
- TIMEOUT_CYCLES, 500000000, idle cycles before auto-clear when SEQ_TIMEOUT_EN is defined (10 s at 50 MHz).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sw_num  in  3  operand switches, bit 2 = MSB; asynchronous.
- sw_op  in  4  operator switches {add, sub, multi, div} = bits [3:0]; asynchronous.
- key_enter_n  in  1  raw enter push-button, active-low.
- key_clear_n  in  1  raw clear push-button, active-low.
- num1  out  3  latched operand A.
- num2  out  3  latched operand B.
- add, sub, multi, div  out  1 each  registered one-hot operator; all 0 unless state is SHOW.
- state_led  out  4  one-hot current state {SHOW, GET_B, GET_OP, GET_A} = bits [3:0].
- op_err  out  1  one-cycle pulse when enter is rejected in GET_OP.

Behaviour:
- Reset (rst_n low, asynchronous): state GET_A; num1 = num2 = 0; add/sub/multi/div = 0; op_err = 0; state_led = 4'b0001; debouncers report "released"; counters cleared.
- Input sync: sw_num, sw_op and both keys pass through 2-flop synchronizers.
- Debounce (per key):
  - Counter runs while the synchronized level differs from the debounced level; resets to 0 when the level matches again.
  - The debounced level flips when the counter reaches DEBOUNCE_CYCLES-1.
  - A press event is a one-cycle pulse on the debounced 1->0 transition. Releases generate no event.
- Press latency: 2 sync cycles + DEBOUNCE_CYCLES to the event pulse; FSM registers update on the following edge.
- FSM on enter event:
  - GET_A -> GET_OP: num1 <= synchronized sw_num.
  - GET_OP, sw_op exactly one-hot: latch operator internally; -> GET_B.
  - GET_OP, sw_op zero or multi-hot: op_err pulses 1 cycle; state unchanged.
  - GET_B -> SHOW: num2 <= synchronized sw_num. Operator outputs assert on the same edge as the state change.
  - SHOW -> GET_A: num1, num2 and operator outputs cleared to 0.
- Clear event, any state: -> GET_A with all outputs at reset values.
- Clear and enter events in the same cycle: clear wins; enter is discarded.
- Switches in SHOW: changes have no effect; outputs stay latched.
- Held key: produces one event only. Repeat requires release, stable for DEBOUNCE_CYCLES, then a new press.
- Bounce: glitches shorter than DEBOUNCE_CYCLES produce no event.
- Outputs: all are registers, with no combinational path from the switches. Operator outputs are 0 outside SHOW, so the downstream result reads zero during entry.

Optional Feature:
- SEQ_TIMEOUT_EN defined:
  - A 32-bit idle counter increments every cycle in GET_OP, GET_B or SHOW.
  - It resets on any enter or clear event and is held at 0 in GET_A.
  - On reaching TIMEOUT_CYCLES-1 the block performs a clear (-> GET_A, outputs zeroed) on the next edge.
- SEQ_TIMEOUT_EN undefined: no counter; state is held indefinitely until enter or clear.

Test Plan:
- Bench uses DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=50.
- Full sequence: sw_num=3'b101 + enter; sw_op=4'b0010 (multi) + enter; sw_num=3'b011 + enter -> num1=5, num2=3, multi=1 only after the third event; state_led=4'b1000; operator lines 0 before that edge.
- Bounce: enter toggled low/high in 2-cycle glitches for 20 cycles, then held low -> exactly one event; num1 latched once; no extra state advance.
- Bad operator: in GET_OP, sw_op=4'b1100 + enter -> op_err high exactly 1 cycle; state_led stays 4'b0010. Then sw_op=4'b1000 + enter -> GET_B, add latched.
- Clear priority: in GET_B, enter and clear debounced-pressed on the same cycle -> GET_A; num1=0; no num2 latch.
- Async reset: rst_n pulsed low for 1 ns mid-debounce while in SHOW -> outputs 0 and state_led=4'b0001 immediately, without waiting for a clk edge. Pending press is discarded.
- SEQ_TIMEOUT_EN: enter operand A and leave idle 50 cycles -> returns to GET_A with num1=0. Same test without the macro -> still GET_OP after 1000 cycles.
